alu_station: RTL and testbench
==============================

Name: alu_station

Overview:
- Multi-entry reservation station that sits between issue/decode and the ALU execute unit.
- Accepts decoded ALU-class instructions whose operands may still be tagged.
- Snoops the common result broadcast so waiting operands capture their data as producers complete.
- Dispatches one fully-ready entry per cycle to the ALU as a single-cycle pulse, then frees that entry.

Parameters:
- DEPTH, 4, number of station entries (power of two, 2..16).
- TAG_W, 4, width of regtag_t. UNLOCKED is the all-zero tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, state and outputs freeze
- flush  in  1  jump/mispredict clear; empties every entry
- issue_valid  in  1  issue presents an instruction
- issue_ready  out  1  station can accept (registered; high iff at least one entry free)
- issue_op  in  6  sinst_t opcode
- issue_pc  in  32  instruction address
- issue_tagx / issue_tagy / issue_tagw  in  TAG_W each  producer tags (UNLOCKED = value valid)
- issue_datax / issue_datay  in  32 each  operand values, used when the matching tag is UNLOCKED
- issue_target  in  5  destination regaddr_t
- cdb_en  in  1  result broadcast valid
- cdb_tag  in  TAG_W  producer tag being completed
- cdb_data  in  32  broadcast value
- alu_busy_out  out  1  dispatch pulse to the ALU
- alu_op  out  6  opcode
- alu_pc  out  32  pc
- alu_tagx / alu_tagy / alu_tagw  out  TAG_W each  always UNLOCKED
- alu_datax / alu_datay  out  32 each  operand values
- alu_target  out  5  destination register

Behaviour:
- Reset (rst high at a rising edge; takes priority over rdy and flush):
  - All entries invalid.
  - issue_ready=1.
  - alu_busy_out=0; all alu_* data/op/pc/target outputs = 0; alu_tag* = UNLOCKED.
- rdy=0: no entry, capture or output changes; the issue handshake does not complete.
- Per-entry state:
  - valid, op, pc, target.
  - tagx/tagy/tagw with datax/datay.
  - tagw has no data field; it clears only on a matching broadcast.
- Issue:
  - A transfer occurs on an edge where issue_valid && issue_ready && rdy && !flush.
  - The instruction is written to the lowest-index invalid entry, selected from pre-edge state.
  - Same-edge bypass: if cdb_en and cdb_tag equals a nonzero issue tag, that tag is stored as UNLOCKED and, for x/y, the data field takes cdb_data.
- Wakeup:
  - On each enabled edge, every valid entry with tag == cdb_tag (nonzero) and cdb_en set clears that tag to UNLOCKED.
  - For x/y, the matching data field is loaded with cdb_data.
  - Any number of entries and fields may match in the same edge.
- Ready:
  - An entry is ready when it is valid and all three tags are UNLOCKED, evaluated on pre-edge state.
  - Wakeup and dispatch are never combined in one edge.
- Dispatch:
  - On each enabled edge, the lowest-index ready entry is copied to the alu_* registers, alu_busy_out<=1, and the entry is invalidated.
  - If no entry is ready, alu_busy_out<=0 and the data outputs hold.
  - alu_busy_out is high for exactly one cycle per dispatched instruction.
  - The ALU consumes unconditionally, so there is no back-pressure.
- Latency:
  - An instruction issued with all tags UNLOCKED at edge E drives alu_busy_out after edge E+1.
  - A last-operand broadcast at edge E gives dispatch after edge E+1.
- issue_ready:
  - Registered as (free count after this edge) > 0.
  - An entry freed by dispatch at edge E is allocatable from edge E+1.
- Full: issue_ready=0. issue_valid is ignored and issue must hold its instruction.
- Flush (flush high with rdy high):
  - All entries are invalidated and alu_busy_out<=0.
  - Any issue and dispatch on that edge are cancelled.
  - issue_ready<=1.
- Simultaneous flush and rst: reset wins; the result is identical.
- Tag UNLOCKED on cdb_tag never matches anything (a zero tag is ignored even if cdb_en is high).

Decomposition:
- The shared cpu defines header provides word_t, addr_t, regaddr_t, sinst_t, regtag_t (TAG_W), UNLOCKED, ZERO, and the opcode constants.
- One sub-module, alu_station_pick: a parameterised lowest-index priority encoder (vector in -> index + found). It is instantiated twice: once for free-entry selection and once for ready-entry selection.

Test Plan:
- Reset, then issue ADD (tags UNLOCKED, x=5, y=7, target=3) -> alu_busy_out high for one cycle, 2 cycles after issue edge, alu_datax=5, alu_datay=7, alu_target=3, alu_tag*=0.
- Issue SUB with tagx=2, then hold cdb idle 5 cycles -> no dispatch. Then cdb_en, tag 2, data 0x10 -> dispatch next cycle with alu_datax=0x10.
- Fill all 4 entries with tagx=1 -> issue_ready=0 and a 5th issue_valid is not accepted. One cdb tag 1 broadcast -> entries dispatch one per cycle in index order 0..3; issue_ready returns after the first dispatch.
- Issue tagy=3 on the same edge that cdb broadcasts tag 3 with data 0xABCD -> dispatch next cycle with alu_datay=0xABCD (bypass).
- Two entries waiting, pulse flush -> alu_busy_out stays 0, issue_ready=1, and a later cdb of their tags produces no dispatch.
- Hold rdy=0 with a ready entry and an active cdb -> outputs frozen and nothing lost. rdy=1 -> normal dispatch resumes. Assert rst mid-wait -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/alu_station_pkg.sv
// Shared cpu definitions used by the ALU reservation station: word/address/tag
// types, the UNLOCKED tag value and the ALU opcode constants.
package alu_station_pkg;

   localparam int DEF_TAG_W = 4;

   typedef logic [31:0]          word_t;
   typedef logic [31:0]          addr_t;
   typedef logic [4:0]           regaddr_t;
   typedef logic [5:0]           sinst_t;
   typedef logic [DEF_TAG_W-1:0] regtag_t;

   localparam regtag_t UNLOCKED = '0;
   localparam word_t   ZERO     = '0;

   localparam sinst_t OP_NOP = 6'h00;
   localparam sinst_t OP_ADD = 6'h01;
   localparam sinst_t OP_SUB = 6'h02;
   localparam sinst_t OP_AND = 6'h03;
   localparam sinst_t OP_OR  = 6'h04;
   localparam sinst_t OP_XOR = 6'h05;
   localparam sinst_t OP_SLL = 6'h06;
   localparam sinst_t OP_SRL = 6'h07;

endpackage

// File: rtl/alu_station_pick.sv
// Lowest-index priority encoder: returns the index of the lowest set bit of vec
// and whether any bit was set.
module alu_station_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scanning from the top down lets the lowest set bit win.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_station.sv
// ALU reservation station: holds issued instructions until their operand tags
// are resolved from the result broadcast, then dispatches one per cycle.
module alu_station
   import alu_station_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [5:0]       issue_op,
   input  logic [31:0]      issue_pc,
   input  logic [TAG_W-1:0] issue_tagx,
   input  logic [TAG_W-1:0] issue_tagy,
   input  logic [TAG_W-1:0] issue_tagw,
   input  logic [31:0]      issue_datax,
   input  logic [31:0]      issue_datay,
   input  logic [4:0]       issue_target,
   input  logic             cdb_en,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   output logic             alu_busy_out,
   output logic [5:0]       alu_op,
   output logic [31:0]      alu_pc,
   output logic [TAG_W-1:0] alu_tagx,
   output logic [TAG_W-1:0] alu_tagy,
   output logic [TAG_W-1:0] alu_tagw,
   output logic [31:0]      alu_datax,
   output logic [31:0]      alu_datay,
   output logic [4:0]       alu_target
);

   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0] valid;
   sinst_t           op_q     [DEPTH];
   addr_t            pc_q     [DEPTH];
   regaddr_t         target_q [DEPTH];
   logic [TAG_W-1:0] tagx_q   [DEPTH];
   logic [TAG_W-1:0] tagy_q   [DEPTH];
   logic [TAG_W-1:0] tagw_q   [DEPTH];
   word_t            datax_q  [DEPTH];
   word_t            datay_q  [DEPTH];

   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] valid_nxt;
   logic [IW-1:0]    free_idx, rdy_idx;
   logic             free_found, rdy_found;
   logic             cdb_hit, take;
   logic             byp_x, byp_y, byp_w;

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         ready_vec[i] = valid[i] && (tagx_q[i] == '0) && (tagy_q[i] == '0) && (tagw_q[i] == '0);
   end

   alu_station_pick #(.N(DEPTH), .IW(IW)) u_pick_free (
      .vec   (~valid),
      .idx   (free_idx),
      .found (free_found)
   );

   alu_station_pick #(.N(DEPTH), .IW(IW)) u_pick_ready (
      .vec   (ready_vec),
      .idx   (rdy_idx),
      .found (rdy_found)
   );

   // A zero tag on the broadcast means "no producer" and must never match.
   assign cdb_hit = cdb_en && (cdb_tag != '0);
   assign take    = issue_valid && issue_ready && free_found;
   assign byp_x   = cdb_hit && (issue_tagx == cdb_tag);
   assign byp_y   = cdb_hit && (issue_tagy == cdb_tag);
   assign byp_w   = cdb_hit && (issue_tagw == cdb_tag);

   // Dispatched slot is freed and a new slot is claimed in the same edge; both
   // come from pre-edge state so they can never be the same entry.
   always_comb begin
      valid_nxt = valid;
      if (rdy_found) valid_nxt[rdy_idx] = 1'b0;
      if (take)      valid_nxt[free_idx] = 1'b1;
   end

   assign alu_tagx = '0;
   assign alu_tagy = '0;
   assign alu_tagw = '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid        <= '0;
         issue_ready  <= 1'b1;
         alu_busy_out <= 1'b0;
         alu_op       <= '0;
         alu_pc       <= '0;
         alu_datax    <= '0;
         alu_datay    <= '0;
         alu_target   <= '0;
      end else if (rdy) begin
         if (flush) begin
            valid        <= '0;
            alu_busy_out <= 1'b0;
            issue_ready  <= 1'b1;
         end else begin
            valid       <= valid_nxt;
            issue_ready <= |(~valid_nxt);

            for (int i = 0; i < DEPTH; i++) begin
               if (valid[i] && cdb_hit) begin
                  if (tagx_q[i] == cdb_tag) begin
                     tagx_q[i]  <= '0;
                     datax_q[i] <= cdb_data;
                  end
                  if (tagy_q[i] == cdb_tag) begin
                     tagy_q[i]  <= '0;
                     datay_q[i] <= cdb_data;
                  end
                  if (tagw_q[i] == cdb_tag) tagw_q[i] <= '0;
               end
            end

            alu_busy_out <= rdy_found;
            if (rdy_found) begin
               alu_op     <= op_q[rdy_idx];
               alu_pc     <= pc_q[rdy_idx];
               alu_datax  <= datax_q[rdy_idx];
               alu_datay  <= datay_q[rdy_idx];
               alu_target <= target_q[rdy_idx];
            end

            if (take) begin
               op_q[free_idx]     <= issue_op;
               pc_q[free_idx]     <= issue_pc;
               target_q[free_idx] <= issue_target;
               tagx_q[free_idx]   <= byp_x ? '0 : issue_tagx;
               tagy_q[free_idx]   <= byp_y ? '0 : issue_tagy;
               tagw_q[free_idx]   <= byp_w ? '0 : issue_tagw;
               datax_q[free_idx]  <= byp_x ? cdb_data : issue_datax;
               datay_q[free_idx]  <= byp_y ? cdb_data : issue_datay;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_station.sv
// Directed bench for alu_station: a behavioural station model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_alu_station;
   import alu_station_pkg::*;

   localparam int DEPTH = 4;
   localparam int TW    = 4;

   logic          clk = 1'b0;
   logic          rst, rdy, flush, issue_valid, issue_ready, cdb_en;
   logic [5:0]    issue_op, alu_op;
   logic [31:0]   issue_pc, issue_datax, issue_datay, cdb_data;
   logic [TW-1:0] issue_tagx, issue_tagy, issue_tagw, cdb_tag;
   logic [4:0]    issue_target, alu_target;
   logic          alu_busy_out;
   logic [31:0]   alu_pc, alu_datax, alu_datay;
   logic [TW-1:0] alu_tagx, alu_tagy, alu_tagw;

   always #5 clk = ~clk;

   alu_station #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_pc(issue_pc), .issue_tagx(issue_tagx), .issue_tagy(issue_tagy),
      .issue_tagw(issue_tagw), .issue_datax(issue_datax), .issue_datay(issue_datay),
      .issue_target(issue_target), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .alu_busy_out(alu_busy_out), .alu_op(alu_op), .alu_pc(alu_pc),
      .alu_tagx(alu_tagx), .alu_tagy(alu_tagy), .alu_tagw(alu_tagw),
      .alu_datax(alu_datax), .alu_datay(alu_datay), .alu_target(alu_target)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a table of waiting instructions, each with its
   // unresolved producer tags.
   typedef struct {
      bit          v;
      logic [5:0]  op;
      logic [31:0] pc;
      logic [3:0]  tx, ty, tw;
      logic [31:0] dx, dy;
      logic [4:0]  tg;
   } ent_t;

   ent_t        m [DEPTH];
   bit          e_busy, e_ready;
   logic [5:0]  e_op;
   logic [31:0] e_pc, e_dx, e_dy;
   logic [4:0]  e_tg;

   always @(posedge clk) begin : model
      int d, f;
      bit hit, take;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
         e_busy = 0; e_ready = 1; e_op = 0; e_pc = 0; e_dx = 0; e_dy = 0; e_tg = 0;
      end else if (rdy) begin
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            e_busy = 0; e_ready = 1;
         end else begin
            d = -1; f = -1;
            for (int i = 0; i < DEPTH; i++) begin
               if (d < 0 && m[i].v && m[i].tx == 0 && m[i].ty == 0 && m[i].tw == 0) d = i;
               if (f < 0 && !m[i].v) f = i;
            end
            hit  = cdb_en && cdb_tag != 0;
            take = issue_valid && e_ready && f >= 0;
            if (hit)
               for (int i = 0; i < DEPTH; i++)
                  if (m[i].v) begin
                     if (m[i].tx == cdb_tag) begin m[i].tx = 0; m[i].dx = cdb_data; end
                     if (m[i].ty == cdb_tag) begin m[i].ty = 0; m[i].dy = cdb_data; end
                     if (m[i].tw == cdb_tag) m[i].tw = 0;
                  end
            e_busy = (d >= 0);
            if (d >= 0) begin
               e_op = m[d].op; e_pc = m[d].pc; e_dx = m[d].dx; e_dy = m[d].dy; e_tg = m[d].tg;
               m[d].v = 0;
            end
            if (take) begin
               m[f] = '{1'b1, issue_op, issue_pc, issue_tagx, issue_tagy, issue_tagw,
                        issue_datax, issue_datay, issue_target};
               if (hit && issue_tagx == cdb_tag) begin m[f].tx = 0; m[f].dx = cdb_data; end
               if (hit && issue_tagy == cdb_tag) begin m[f].ty = 0; m[f].dy = cdb_data; end
               if (hit && issue_tagw == cdb_tag) m[f].tw = 0;
            end
            e_ready = 0;
            for (int i = 0; i < DEPTH; i++) if (!m[i].v) e_ready = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy",   alu_busy_out, e_busy);
         chk("ready",  issue_ready,  e_ready);
         chk("op",     alu_op,       e_op);
         chk("pc",     alu_pc,       e_pc);
         chk("datax",  alu_datax,    e_dx);
         chk("datay",  alu_datay,    e_dy);
         chk("target", alu_target,   e_tg);
         chk("tags",   {alu_tagx, alu_tagy, alu_tagw}, 0);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      issue_valid = 0; cdb_en = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
   endtask

   task automatic put(input logic [5:0] op, input logic [31:0] pc, input logic [3:0] tx,
                      input logic [3:0] ty, input logic [3:0] tw, input logic [31:0] dx,
                      input logic [31:0] dy, input logic [4:0] tg);
      issue_valid = 1; issue_op = op; issue_pc = pc; issue_tagx = tx; issue_tagy = ty;
      issue_tagw = tw; issue_datax = dx; issue_datay = dy; issue_target = tg;
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] d);
      cdb_en = 1; cdb_tag = t; cdb_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end of sequence");
      $fatal(1);
   end

   initial begin
      rst = 1; rdy = 1; idle();
      put(OP_NOP, 0, 0, 0, 0, 0, 0, 0); issue_valid = 0;
      cyc(); cyc();
      chk("rst_ready", issue_ready, 1);
      chk("rst_busy",  alu_busy_out, 0);
      chk("rst_pc",    alu_pc, 0);
      rst = 0; cmp_en = 1;

      // ADD with everything resolved: pulse two edges after issue
      put(OP_ADD, 32'h10, 0, 0, 0, 5, 7, 3); cyc(); idle();
      cyc();
      chk("add_busy", alu_busy_out, 1); chk("add_x", alu_datax, 5);
      chk("add_y", alu_datay, 7); chk("add_tgt", alu_target, 3); chk("add_op", alu_op, OP_ADD);
      cyc();
      chk("add_one_pulse", alu_busy_out, 0);

      // SUB waiting on tag 2; zero-tag broadcasts must not wake it
      put(OP_SUB, 32'h20, 2, 0, 0, 32'h999, 3, 4); cyc(); idle();
      for (int i = 0; i < 5; i++) begin
         cdb(0, 32'hBAD); cyc();
         chk("sub_wait", alu_busy_out, 0);
      end
      cdb(2, 32'h10); cyc(); idle();
      chk("sub_no_same_edge", alu_busy_out, 0);
      cyc();
      chk("sub_busy", alu_busy_out, 1); chk("sub_x", alu_datax, 32'h10); chk("sub_y", alu_datay, 3);

      // Fill all entries on tag 1, then release them with one broadcast
      for (int i = 0; i < 4; i++) begin
         put(OP_AND, 32'h100 + 4 * i, 1, 0, 0, 0, i, 5'(8 + i)); cyc();
      end
      chk("full_ready", issue_ready, 0);
      put(OP_OR, 32'h200, 0, 0, 0, 1, 1, 1); cyc(); cyc();
      chk("full_ready_hold", issue_ready, 0); chk("full_no_disp", alu_busy_out, 0);
      idle(); cdb(1, 32'h11); cyc(); idle();
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("drain_busy", alu_busy_out, 1);
         chk("drain_pc", alu_pc, 32'h100 + 4 * i);
         chk("drain_x", alu_datax, 32'h11);
         if (i == 0) chk("drain_ready_back", issue_ready, 1);
      end
      cyc();
      chk("drain_done", alu_busy_out, 0);

      // Same-edge bypass of tagy
      put(OP_XOR, 32'h400, 0, 3, 0, 1, 32'hDEAD, 6); cdb(3, 32'hABCD); cyc(); idle();
      cyc();
      chk("byp_busy", alu_busy_out, 1); chk("byp_y", alu_datay, 32'hABCD); chk("byp_x", alu_datax, 1);

      // Flush two waiting entries plus a concurrent issue
      put(OP_SLL, 32'h500, 5, 0, 0, 0, 0, 1); cyc();
      put(OP_SRL, 32'h504, 0, 0, 6, 0, 0, 2); cyc();
      put(OP_ADD, 32'h5F0, 0, 0, 0, 0, 0, 3); flush = 1; cyc(); idle();
      chk("fl_busy", alu_busy_out, 0); chk("fl_ready", issue_ready, 1);
      cyc(); chk("fl_cancel_issue", alu_busy_out, 0);
      cdb(5, 1); cyc(); cdb(6, 2); cyc(); idle();
      cyc(); chk("fl_gone_a", alu_busy_out, 0);
      cyc(); chk("fl_gone_b", alu_busy_out, 0);

      // rdy low freezes everything; then reset mid-wait
      put(OP_SUB, 32'h600, 7, 0, 0, 0, 0, 9); cyc();
      put(OP_ADD, 32'h700, 0, 0, 0, 32'h55, 0, 10); cyc(); idle();
      rdy = 0; cdb(7, 32'h77);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("frz_busy", alu_busy_out, 0); chk("frz_pc", alu_pc, 32'h400);
      end
      rdy = 1; idle(); cyc();
      chk("rsm_busy", alu_busy_out, 1); chk("rsm_pc", alu_pc, 32'h700); chk("rsm_x", alu_datax, 32'h55);
      cyc(); chk("rsm_wait", alu_busy_out, 0);
      rst = 1; flush = 1; cyc(); rst = 0; flush = 0;
      chk("rst2_pc", alu_pc, 0); chk("rst2_op", alu_op, 0);
      chk("rst2_busy", alu_busy_out, 0); chk("rst2_ready", issue_ready, 1);
      cdb(7, 32'h77); cyc(); idle();
      cyc(); chk("rst2_gone", alu_busy_out, 0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
